lpm_shiftreg_seq: RTL

//  Sequencer for an external LEFT/RIGHT lpm_shiftreg used as a parallel-to-serial converter.

---
 rtl/lpm_shiftreg_seq_pkg.sv | 32 +++
 rtl/lpm_shiftreg_seq_bitdiv.sv | 64 ++++++
 rtl/lpm_shiftreg_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lpm_shiftreg_seq_pkg.sv
// -----------------------------------------------------------------------------
// lpm_shiftreg_seq_pkg
//   Shared types and helpers for the lpm_shiftreg sequencer.
//   - seq_state_e : sequencer FSM state encoding (3 bits, IDLE..CLEAR)
//   - cnt_width() : counter width helper, never returns less than one bit
// -----------------------------------------------------------------------------
package lpm_shiftreg_seq_pkg;

   // Sequencer states. IDLE is encoded as zero so a cleared state register
   // is always a legal, quiescent state.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_CLEAR = 3'd4
   } seq_state_e;

   // Number of bits needed to hold the values 0 .. n_values-1.
   // A counter is always at least one bit wide, even when it only ever
   // holds zero (e.g. clk_div = 1 or gap_cycles = 0).
   function automatic int cnt_width(input int n_values);
      int w;
      if (n_values <= 1) begin
         w = 1;
      end else begin
         w = $clog2(n_values);
      end
      return w;
   endfunction

endpackage : lpm_shiftreg_seq_pkg

// File: rtl/lpm_shiftreg_seq_bitdiv.sv
// -----------------------------------------------------------------------------
// lpm_shiftreg_seq_bitdiv
//   Bit-period divider for the shiftreg sequencer. While 'run' is high the
//   divider walks divcnt through 0 .. clk_div-1 once per serial bit.
//
//   'run', 'strobe' and 'tick' all describe the NEXT clock cycle: the parent
//   drives 'run' from its next-state logic and registers 'strobe'/'tick' into
//   its own outputs, so the registered outputs line up with the cycle in
//   which the shiftreg actually sees them.
//
// Ports
//   clock  in   rising-edge clock
//   aclr_n in   async active-low reset
//   run    in   next cycle belongs to the SHIFT phase
//   strobe out  next cycle is the first clock of a bit period
//   tick   out  next cycle is the last clock of a bit period (shift cycle)
// -----------------------------------------------------------------------------
module lpm_shiftreg_seq_bitdiv
   import lpm_shiftreg_seq_pkg::*;
#(
   parameter int clk_div = 1
) (
   input  logic clock,
   input  logic aclr_n,
   input  logic run,
   output logic strobe,
   output logic tick
);

   localparam int             DW       = cnt_width(clk_div);
   localparam logic [DW-1:0]  DIV_LAST = DW'(clk_div - 1);

   logic [DW-1:0] divcnt_q;
   logic [DW-1:0] divcnt_d;
   logic          run_q;

   // Next divider value: restart at 0 on entry to SHIFT and after each bit period.
   always_comb begin
      divcnt_d = '0;
      if (run && run_q && (divcnt_q != DIV_LAST)) begin
         divcnt_d = divcnt_q + DW'(1);
      end else begin
         divcnt_d = '0;
      end
   end

   // Decode of the next-cycle position inside the bit period.
   always_comb begin
      strobe = run && (divcnt_d == '0);
      tick   = run && (divcnt_d == DIV_LAST);
   end

   // Divider state registers.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         divcnt_q <= '0;
         run_q    <= 1'b0;
      end else begin
         divcnt_q <= divcnt_d;
         run_q    <= run;
      end
   end

endmodule : lpm_shiftreg_seq_bitdiv

// File: rtl/lpm_shiftreg_seq.sv
// -----------------------------------------------------------------------------
// lpm_shiftreg_seq
//   Sequencer driving an external LEFT-shifting lpm_shiftreg as a
//   parallel-to-serial converter. One word is accepted per valid/ready
//   handshake, loaded into the shiftreg, shifted out one bit per clk_div
//   clocks (MSB first on shiftout), then an optional idle gap is inserted
//   before the next word is accepted. A synchronous abort stops the word in
//   flight and clears the shiftreg.
//
// Parameters
//   lpm_width  word width, must match the driven shiftreg (>= 1)
//   clk_div    clocks per serial bit (>= 1)
//   gap_cycles idle clocks after each word (>= 0)
//   fill_bit   value driven on sr_shiftin
//
// Ports
//   clock      in   rising-edge clock
//   aclr_n     in   async active-low reset
//   data_in    in   word to serialise
//   data_valid in   data_in valid
//   data_ready out  can accept a word (IDLE and no abort), combinational
//   abort      in   synchronous abort of the word in flight
//   sr_data    out  captured word, to shiftreg data
//   sr_load    out  to shiftreg load
//   sr_enable  out  to shiftreg enable
//   sr_sclr    out  to shiftreg sclr
//   sr_shiftin out  to shiftreg shiftin
//   sr_aclr    out  to shiftreg aclr, combinational inverse of aclr_n
//   busy       out  sequencer not idle
//   bit_strobe out  pulse on the first clock of each bit period
//   done       out  pulse on the clock of the final shift (never on abort)
//
// Timing (counting edges from, and including, the accept edge)
//   first bit on shiftout after 2 edges; data_ready back after
//   1 + lpm_width*clk_div + gap_cycles + 1 edges.
// -----------------------------------------------------------------------------
module lpm_shiftreg_seq
   import lpm_shiftreg_seq_pkg::*;
#(
   parameter int   lpm_width  = 8,
   parameter int   clk_div    = 1,
   parameter int   gap_cycles = 0,
   parameter logic fill_bit   = 1'b1
) (
   input  logic                 clock,
   input  logic                 aclr_n,
   input  logic [lpm_width-1:0] data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   input  logic                 abort,
   output logic [lpm_width-1:0] sr_data,
   output logic                 sr_load,
   output logic                 sr_enable,
   output logic                 sr_sclr,
   output logic                 sr_shiftin,
   output logic                 sr_aclr,
   output logic                 busy,
   output logic                 bit_strobe,
   output logic                 done
);

   localparam int            BW       = cnt_width(lpm_width + 1);
   localparam int            GW       = cnt_width(gap_cycles + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(lpm_width - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((gap_cycles > 0) ? (gap_cycles - 1) : 0);
   localparam bit            HAS_GAP  = (gap_cycles > 0);

   seq_state_e           state_q;
   seq_state_e           state_d;
   logic [BW-1:0]        bitcnt_q;
   logic [BW-1:0]        bitcnt_d;
   logic [GW-1:0]        gapcnt_q;
   logic [GW-1:0]        gapcnt_d;
   logic [lpm_width-1:0] sr_data_q;
   logic [lpm_width-1:0] sr_data_d;
   logic                 sr_load_q;
   logic                 sr_load_d;
   logic                 sr_enable_q;
   logic                 sr_enable_d;
   logic                 sr_sclr_q;
   logic                 sr_sclr_d;
   logic                 sr_shiftin_q;
   logic                 busy_q;
   logic                 busy_d;
   logic                 bit_strobe_q;
   logic                 bit_strobe_d;
   logic                 done_q;
   logic                 done_d;

   logic                 data_ready_s;
   logic                 accept_s;
   logic                 shift_now_s;
   logic                 last_shift_s;
   logic                 run_s;
   logic                 strobe_s;
   logic                 tick_s;

   // Handshake and current-cycle shift decode. In SHIFT the registered
   // sr_enable is high exactly in the clocks where the shiftreg shifts.
   always_comb begin
      data_ready_s = (state_q == ST_IDLE) && !abort;
      accept_s     = data_valid && data_ready_s;
      shift_now_s  = (state_q == ST_SHIFT) && sr_enable_q;
      last_shift_s = shift_now_s && (bitcnt_q == BIT_LAST);
      run_s        = (state_d == ST_SHIFT);
   end

   lpm_shiftreg_seq_bitdiv #(
      .clk_div (clk_div)
   ) u_bitdiv (
      .clock  (clock),
      .aclr_n (aclr_n),
      .run    (run_s),
      .strobe (strobe_s),
      .tick   (tick_s)
   );

   // FSM next-state logic; abort always wins over normal progress.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_CLEAR;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_CLEAR;
            end else if (last_shift_s) begin
               state_d = HAS_GAP ? ST_GAP : ST_IDLE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_CLEAR;
            end else if (gapcnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GAP;
            end
         end
         ST_CLEAR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bit and gap counters: bitcnt is the index of the bit on shiftout,
   // gapcnt counts idle clocks; both return to zero outside their phase.
   always_comb begin
      bitcnt_d = bitcnt_q;
      gapcnt_d = '0;
      if (state_d != ST_SHIFT) begin
         bitcnt_d = '0;
      end else if (shift_now_s) begin
         bitcnt_d = bitcnt_q + BW'(1);
      end else begin
         bitcnt_d = bitcnt_q;
      end
      if ((state_q == ST_GAP) && (state_d == ST_GAP)) begin
         gapcnt_d = gapcnt_q + GW'(1);
      end else begin
         gapcnt_d = '0;
      end
   end

   // Output next values, all derived from the next state so the registered
   // outputs are valid during the state they belong to. done is raised for
   // the cycle whose shift moves past the last bit.
   always_comb begin
      sr_data_d = sr_data_q;
      if (accept_s) begin
         sr_data_d = data_in;
      end else begin
         sr_data_d = sr_data_q;
      end
      sr_load_d    = (state_d == ST_LOAD);
      sr_sclr_d    = (state_d == ST_CLEAR);
      sr_enable_d  = (state_d == ST_LOAD) || (state_d == ST_CLEAR) || tick_s;
      busy_d       = (state_d != ST_IDLE);
      bit_strobe_d = strobe_s;
      done_d       = tick_s && (bitcnt_d == BIT_LAST);
   end

   // State, counter and output registers.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q      <= ST_IDLE;
         bitcnt_q     <= '0;
         gapcnt_q     <= '0;
         sr_data_q    <= '0;
         sr_load_q    <= 1'b0;
         sr_enable_q  <= 1'b0;
         sr_sclr_q    <= 1'b0;
         sr_shiftin_q <= fill_bit;
         busy_q       <= 1'b0;
         bit_strobe_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         gapcnt_q     <= gapcnt_d;
         sr_data_q    <= sr_data_d;
         sr_load_q    <= sr_load_d;
         sr_enable_q  <= sr_enable_d;
         sr_sclr_q    <= sr_sclr_d;
         sr_shiftin_q <= fill_bit;
         busy_q       <= busy_d;
         bit_strobe_q <= bit_strobe_d;
         done_q       <= done_d;
      end
   end

   assign data_ready = data_ready_s;
   assign sr_aclr    = ~aclr_n;
   assign sr_data    = sr_data_q;
   assign sr_load    = sr_load_q;
   assign sr_enable  = sr_enable_q;
   assign sr_sclr    = sr_sclr_q;
   assign sr_shiftin = sr_shiftin_q;
   assign busy       = busy_q;
   assign bit_strobe = bit_strobe_q;
   assign done       = done_q;

endmodule : lpm_shiftreg_seq
